// File: rtl/pkt_mux_nch_if.sv
// rtl/pkt_mux_nch_if.sv - channel-side and output-side signal bundle of the packet mux
interface pkt_mux_nch_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 134
);
  logic [NUM_CH-1:0]        in_data_wr;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_valid_wr;
  logic [NUM_CH-1:0]        in_alf;
  logic                     out_data_wr;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_valid_wr;
  logic                     out_alf;

  modport master (
    output in_data_wr, in_data, in_valid, in_valid_wr, out_alf,
    input  in_alf, out_data_wr, out_data, out_valid, out_valid_wr
  );

  modport slave (
    input  in_data_wr, in_data, in_valid, in_valid_wr, out_alf,
    output in_alf, out_data_wr, out_data, out_valid, out_valid_wr
  );
endinterface

// File: rtl/pkt_mux_nch.sv
// rtl/pkt_mux_nch.sv - N-channel whole-packet multiplexer with per-channel data/valid FIFOs
module pkt_mux_nch #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 134,
  parameter int DFIFO_AW   = 8,
  parameter int VFIFO_AW   = 6,
  parameter int ALF_MARGIN = 128,
  parameter int ARB_MODE   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pkt_mux_nch_if.slave         bus,
  output logic [NUM_CH-1:0]    ovf_err,
  output logic [NUM_CH*32-1:0] pkt_cnt
);
  localparam int DDEPTH = 1 << DFIFO_AW;
  localparam int VDEPTH = 1 << VFIFO_AW;
  localparam int CH_W   = $clog2(NUM_CH);
  localparam logic [1:0] FT_TAIL = 2'b10;

  typedef enum logic {IDLE, XFER} state_t;

  logic [DATA_W-1:0] d_q [NUM_CH];
  logic [NUM_CH-1:0] v_q, d_rd, v_rd, eligible, head_is_tail, alf, ovf;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DATA_W-1:0]   dmem [DDEPTH];
    logic [VDEPTH-1:0]   vmem;
    logic [DFIFO_AW-1:0] d_wp, d_rp;
    logic [DFIFO_AW:0]   d_cnt, d_free;
    logic [VFIFO_AW-1:0] v_wp, v_rp;
    logic [VFIFO_AW:0]   v_cnt;
    logic [DATA_W-1:0]   rdat;
    logic                rval, ovf_r, d_full, v_full, d_we, v_we;

    assign d_full = d_cnt == (DFIFO_AW+1)'(DDEPTH);
    assign v_full = v_cnt == (VFIFO_AW+1)'(VDEPTH);
    // A full FIFO still accepts a write when the same cycle pops an entry.
    assign d_we   = bus.in_data_wr[i]  && (!d_full || d_rd[i]);
    assign v_we   = bus.in_valid_wr[i] && (!v_full || v_rd[i]);
    assign d_free = (DFIFO_AW+1)'(DDEPTH) - d_cnt;

    assign alf[i]          = int'(d_free) <= ALF_MARGIN;
    assign eligible[i]     = v_cnt != '0;
    assign head_is_tail[i] = dmem[d_rp][DATA_W-1 -: 2] == FT_TAIL;
    assign d_q[i]          = rdat;
    assign v_q[i]          = rval;
    assign ovf[i]          = ovf_r;

    always_ff @(posedge clk) begin
      if (d_we) dmem[d_wp] <= bus.in_data[i*DATA_W +: DATA_W];
      if (v_we) vmem[v_wp] <= bus.in_valid[i];
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        d_wp  <= '0;
        d_rp  <= '0;
        d_cnt <= '0;
        v_wp  <= '0;
        v_rp  <= '0;
        v_cnt <= '0;
        rdat  <= '0;
        rval  <= 1'b0;
        ovf_r <= 1'b0;
      end else begin
        if (d_we) d_wp <= d_wp + 1'b1;
        if (v_we) v_wp <= v_wp + 1'b1;
        if (d_rd[i]) begin
          rdat <= dmem[d_rp];
          d_rp <= d_rp + 1'b1;
        end
        if (v_rd[i]) begin
          rval <= vmem[v_rp];
          v_rp <= v_rp + 1'b1;
        end
        d_cnt <= d_cnt + (DFIFO_AW+1)'(d_we) - (DFIFO_AW+1)'(d_rd[i]);
        v_cnt <= v_cnt + (VFIFO_AW+1)'(v_we) - (VFIFO_AW+1)'(v_rd[i]);
        if ((bus.in_data_wr[i] && d_full && !d_rd[i]) ||
            (bus.in_valid_wr[i] && v_full && !v_rd[i]))
          ovf_r <= 1'b1;
      end
    end
  end

  assign bus.in_alf = alf;
  assign ovf_err    = ovf;

  state_t            state, state_nxt;
  logic [CH_W-1:0]   gnt, last_gnt, pick, rd_ch;
  logic              found, start, done, rd_active, dout_vld, tail_peek;
  logic [DATA_W-1:0] dout;
  int                idx;

  always_comb begin : arb
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (ARB_MODE == 1) ? k : (int'(last_gnt) + 1 + k) % NUM_CH;
      if (!found && eligible[CH_W'(idx)]) begin
        found = 1'b1;
        pick  = CH_W'(idx);
      end
    end
  end

  always_comb begin : fsm
    state_nxt = state;
    d_rd      = '0;
    v_rd      = '0;
    start     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.out_alf && found) begin
          start     = 1'b1;
          d_rd[pick] = 1'b1;
          v_rd[pick] = 1'b1;
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (rd_active) d_rd[gnt] = 1'b1;
        if (bus.out_valid_wr) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reads stop once the flit leaving the FIFO is a tail, so no flit of the next packet is consumed.
  assign rd_ch     = start ? pick : gnt;
  assign tail_peek = head_is_tail[rd_ch];
  assign dout      = d_q[gnt];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      gnt              <= '0;
      last_gnt         <= CH_W'(NUM_CH - 1);
      rd_active        <= 1'b0;
      dout_vld         <= 1'b0;
      bus.out_data_wr  <= 1'b0;
      bus.out_data     <= '0;
      bus.out_valid    <= 1'b0;
      bus.out_valid_wr <= 1'b0;
      pkt_cnt          <= '0;
    end else begin
      state <= state_nxt;
      if (start) gnt <= pick;
      if (|d_rd) rd_active <= !tail_peek;
      dout_vld         <= |d_rd;
      bus.out_data_wr  <= dout_vld;
      bus.out_data     <= dout_vld ? dout : '0;
      bus.out_valid_wr <= dout_vld && (dout[DATA_W-1 -: 2] == FT_TAIL);
      bus.out_valid    <= dout_vld && (dout[DATA_W-1 -: 2] == FT_TAIL) && v_q[gnt];
      if (done) begin
        last_gnt               <= gnt;
        pkt_cnt[32*gnt +: 32] <= pkt_cnt[32*gnt +: 32] + 32'd1;
      end
    end
  end
endmodule
